// File: rtl/mips_pkg.sv
// Shared ROM widths, response status encodings and the status/data
// formatting applied to every ROM access.
package mips_pkg;

  localparam int ADDR_W = 31;
  localparam int DATA_W = 32;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_MIS = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        err;
  } rom_resp_t;

  // Misalignment is checked first; any error zeroes the returned word.
  function automatic rom_resp_t rom_resp(input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data,
                                         input logic              ovf);
    rom_resp_t r;
    r.data = '0;
    r.err  = ERR_OK;
    if (addr[1:0] != 2'b00) r.err = ERR_MIS;
    else if (ovf)           r.err = ERR_OVF;
    else                    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/rom_resp_buf.sv
// Single-entry response register with valid/ready handshake; reports
// whether its owner may be granted this cycle (empty, or draining now).
module rom_resp_buf
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              load_i,
  input  rom_resp_t         resp_i,
  input  logic              rready_i,
  output logic              elig_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rerr_o
);

  logic      valid_q, valid_d;
  rom_resp_t resp_q, resp_d;

  assign elig_o   = req_i & (~valid_q | rready_i);
  assign rvalid_o = valid_q;
  assign rdata_o  = resp_q.data;
  assign rerr_o   = resp_q.err;

  // A load takes priority over a drain so a same-cycle refill keeps valid high.
  always_comb begin
    valid_d = valid_q;
    resp_d  = resp_q;
    if (load_i) begin
      valid_d = 1'b1;
      resp_d  = resp_i;
    end else if (valid_q && rready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      resp_q  <= '{data: '0, err: ERR_OK};
    end else begin
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates the single ROM read port between instruction fetch (IF) and
// debug reads (DB); IF is preferred but DB is forced in after a bounded burst.
module rom_arbiter
  import mips_pkg::*;
#(
  parameter int IF_BURST_MAX = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              if_rready,
  output logic [DATA_W-1:0] if_rdata,
  output logic [1:0]        if_rerr,
  input  logic              db_req,
  input  logic [ADDR_W-1:0] db_addr,
  output logic              db_gnt,
  output logic              db_rvalid,
  input  logic              db_rready,
  output logic [DATA_W-1:0] db_rdata,
  output logic [1:0]        db_rerr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_overflow
);

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DB = 1'b1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(IF_BURST_MAX);

  logic             if_elig, db_elig, db_win;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_grant_q, last_grant_d;
  rom_resp_t        resp;

  assign db_win = db_elig & (~if_elig | (burst_cnt_q == BURST_LIM));
  // Grants are masked while reset is asserted so nothing is accepted then.
  assign db_gnt = db_win & rst_n;
  assign if_gnt = if_elig & ~db_win & rst_n;

  assign rom_addr = if_gnt ? if_addr : (db_gnt ? db_addr : '0);
  assign resp     = rom_resp(rom_addr, rom_data, rom_overflow);

  always_comb begin
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    if (!db_req || db_gnt)                       burst_cnt_d = '0;
    else if (if_gnt && burst_cnt_q != BURST_LIM) burst_cnt_d = burst_cnt_q + 1'b1;
    if (if_gnt)      last_grant_d = GRANT_IF;
    else if (db_gnt) last_grant_d = GRANT_DB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q  <= '0;
      last_grant_q <= GRANT_IF;
    end else begin
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  rom_resp_buf u_if_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (if_req),
    .load_i   (if_gnt),
    .resp_i   (resp),
    .rready_i (if_rready),
    .elig_o   (if_elig),
    .rvalid_o (if_rvalid),
    .rdata_o  (if_rdata),
    .rerr_o   (if_rerr)
  );

  rom_resp_buf u_db_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (db_req),
    .load_i   (db_gnt),
    .resp_i   (resp),
    .rready_i (db_rready),
    .elig_o   (db_elig),
    .rvalid_o (db_rvalid),
    .rdata_o  (db_rdata),
    .rerr_o   (db_rerr)
  );

endmodule
